// File: rtl/rx_cmd_sequencer_pkg.sv
// rtl/rx_cmd_sequencer_pkg.sv - shared types and constants for the RX command sequencer
// Purpose: FSM state encoding, command opcodes, ALU operand register addresses,
//          and a helper telling which states consume an incoming byte.
// Ports:   none (package).
package rx_cmd_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_LO,
    S_TX_HI
  } state_t;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // write {addr, data}
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // read {addr}
  localparam logic [7:0] CMD_ALU_OPS = 8'hCC;  // ALU with operands {A, B, fun}
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // ALU on stored operands {fun}

  localparam int ALU_A_ADDR = 0;
  localparam int ALU_B_ADDR = 1;

  // States that act on RX bytes; wait and TX states drop them.
  function automatic logic takes_byte(input state_t s);
    case (s)
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
      S_ALU_A, S_ALU_B, S_ALU_FUN: takes_byte = 1'b1;
      default:                     takes_byte = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rx_cmd_sequencer_if.sv
// rtl/rx_cmd_sequencer_if.sv - bus bundle between the sequencer and UART RX, register file, ALU and TX FIFO
// Purpose: groups every non-clock/reset signal of the sequencer.
// Ports (master = sequencer view):
//   in : rx_p_data, rx_d_vld, rx_par_err, rx_stp_err   UART receive byte + flags
//   out: rf_wr_en, rf_rd_en, rf_addr, rf_wr_data       register file access
//   in : rf_rd_data, rf_rd_vld                         register file read return
//   out: alu_en, alu_fun, clk_gate_en                  ALU start / opcode / clock gate
//   in : alu_out, alu_out_vld                          ALU result
//   out: tx_p_data, tx_d_vld   in: tx_full             TX FIFO push
interface rx_cmd_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0]   rx_p_data;
  logic                rx_d_vld;
  logic                rx_par_err;
  logic                rx_stp_err;
  logic                rf_wr_en;
  logic                rf_rd_en;
  logic [ADDR_W-1:0]   rf_addr;
  logic [DATA_W-1:0]   rf_wr_data;
  logic [DATA_W-1:0]   rf_rd_data;
  logic                rf_rd_vld;
  logic                alu_en;
  logic [3:0]          alu_fun;
  logic                clk_gate_en;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_out_vld;
  logic [DATA_W-1:0]   tx_p_data;
  logic                tx_d_vld;
  logic                tx_full;

  modport master (
    input  rx_p_data, rx_d_vld, rx_par_err, rx_stp_err,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    input  rf_rd_data, rf_rd_vld,
    output alu_en, alu_fun, clk_gate_en,
    input  alu_out, alu_out_vld,
    output tx_p_data, tx_d_vld,
    input  tx_full
  );

  modport slave (
    output rx_p_data, rx_d_vld, rx_par_err, rx_stp_err,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data,
    output rf_rd_data, rf_rd_vld,
    input  alu_en, alu_fun, clk_gate_en,
    output alu_out, alu_out_vld,
    input  tx_p_data, tx_d_vld,
    output tx_full
  );
endinterface

// File: rtl/rx_cmd_sequencer.sv
// rtl/rx_cmd_sequencer.sv - decodes UART command bytes into register file, ALU and TX FIFO operations
// Purpose: command FSM. AA addr data -> RF write; BB addr -> RF read, result
//          byte sent to TX; CC A B fun -> operands to RF[0]/RF[1], ALU run,
//          16-bit result sent low byte first; DD fun -> ALU run on stored operands.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  rx_cmd_sequencer_if.master (see interface file)
// Config: RX_CMD_FRAME_ERR_DROP_EN defined -> bytes flagged with parity/stop
//         error abort the current command and return to IDLE.
module rx_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_cmd_sequencer_if.master    bus
);
  import rx_cmd_sequencer_pkg::*;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                two_byte_q, two_byte_d;

  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                alu_en_q, alu_en_d;
  logic                tx_vld_q, tx_vld_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic [3:0]          alu_fun_q, alu_fun_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                gate_q, gate_d;

  logic                byte_ok;
`ifdef RX_CMD_FRAME_ERR_DROP_EN
  logic                byte_err;
  assign byte_err = bus.rx_d_vld & (bus.rx_par_err | bus.rx_stp_err);
  assign byte_ok  = bus.rx_d_vld & ~byte_err;
`else
  logic                unused_err;
  assign unused_err = bus.rx_par_err ^ bus.rx_stp_err;
  assign byte_ok    = bus.rx_d_vld;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    result_d     = result_q;
    two_byte_d   = two_byte_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    alu_en_d     = 1'b0;
    tx_vld_d     = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    tx_data_d    = tx_data_q;

    case (state_q)
      S_IDLE: if (byte_ok) begin
        if (bus.rx_p_data == DATA_W'(CMD_RF_WR))        state_d = S_WR_ADDR;
        else if (bus.rx_p_data == DATA_W'(CMD_RF_RD))   state_d = S_RD_ADDR;
        else if (bus.rx_p_data == DATA_W'(CMD_ALU_OPS)) state_d = S_ALU_A;
        else if (bus.rx_p_data == DATA_W'(CMD_ALU_NOP)) state_d = S_ALU_FUN;
      end
      S_WR_ADDR: if (byte_ok) begin
        addr_d  = bus.rx_p_data[ADDR_W-1:0];
        state_d = S_WR_DATA;
      end
      S_WR_DATA: if (byte_ok) begin
        wr_en_d      = 1'b1;
        rf_addr_d    = addr_q;
        rf_wr_data_d = bus.rx_p_data;
        state_d      = S_IDLE;
      end
      S_RD_ADDR: if (byte_ok) begin
        rd_en_d   = 1'b1;
        rf_addr_d = bus.rx_p_data[ADDR_W-1:0];
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: if (bus.rf_rd_vld) begin
        result_d   = {{DATA_W{1'b0}}, bus.rf_rd_data};
        two_byte_d = 1'b0;
        state_d    = S_TX_LO;
      end
      S_ALU_A: if (byte_ok) begin
        wr_en_d      = 1'b1;
        rf_addr_d    = ADDR_W'(ALU_A_ADDR);
        rf_wr_data_d = bus.rx_p_data;
        state_d      = S_ALU_B;
      end
      S_ALU_B: if (byte_ok) begin
        wr_en_d      = 1'b1;
        rf_addr_d    = ADDR_W'(ALU_B_ADDR);
        rf_wr_data_d = bus.rx_p_data;
        state_d      = S_ALU_FUN;
      end
      S_ALU_FUN: if (byte_ok) begin
        alu_en_d  = 1'b1;
        alu_fun_d = bus.rx_p_data[3:0];
        state_d   = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (bus.alu_out_vld) begin
        result_d   = bus.alu_out;
        two_byte_d = 1'b1;
        state_d    = S_TX_LO;
      end
      S_TX_LO: if (!bus.tx_full) begin
        tx_vld_d  = 1'b1;
        tx_data_d = result_q[DATA_W-1:0];
        state_d   = two_byte_q ? S_TX_HI : S_IDLE;
      end
      S_TX_HI: if (!bus.tx_full) begin
        tx_vld_d  = 1'b1;
        tx_data_d = result_q[2*DATA_W-1:DATA_W];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef RX_CMD_FRAME_ERR_DROP_EN
    // A corrupted byte poisons the whole command; no strobe was raised above
    // because byte_ok is low, so only the state needs overriding.
    if (byte_err && takes_byte(state_q)) state_d = S_IDLE;
`endif

    // Registered from the next state so the gate is high exactly while the
    // FSM sits in ALU_FUN or ALU_WAIT.
    gate_d = (state_d == S_ALU_FUN) || (state_d == S_ALU_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      result_q     <= '0;
      two_byte_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      alu_en_q     <= 1'b0;
      tx_vld_q     <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_fun_q    <= '0;
      tx_data_q    <= '0;
      gate_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      result_q     <= result_d;
      two_byte_q   <= two_byte_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      alu_en_q     <= alu_en_d;
      tx_vld_q     <= tx_vld_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_fun_q    <= alu_fun_d;
      tx_data_q    <= tx_data_d;
      gate_q       <= gate_d;
    end
  end

  assign bus.rf_wr_en    = wr_en_q;
  assign bus.rf_rd_en    = rd_en_q;
  assign bus.rf_addr     = rf_addr_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = gate_q;
  assign bus.tx_p_data   = tx_data_q;
  assign bus.tx_d_vld    = tx_vld_q;

endmodule
